// File: rtl/dmem_req_ctrl.sv
// Requester-side controller for one RAM_SDP: issues reads/writes, returns read data in order via a credit-protected FIFO.
// Optional macro DMEM_WRITE_ACK_EN: writes take a credit and return an in-order ack (rsp_is_write=1, rsp_rdata=0).
module dmem_req_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
`ifdef DMEM_WRITE_ACK_EN
  output logic                  rsp_is_write,
`endif
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_rdaddress,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-1:0] mem_wraddress,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = RSP_DEPTH[CNT_W:0];

  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  inflight;
  logic [CNT_W:0]        used;
  logic                  credit_ok;
  logic                  accept, rd_issue, wr_issue;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];

  // Credits count FIFO entries plus the read in flight; a same-cycle pop is not credited.
  assign used      = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign credit_ok = used < DEPTH_C;

`ifdef DMEM_WRITE_ACK_EN
  assign req_ready = reset_n & credit_ok;
`else
  assign req_ready = reset_n & (req_we | credit_ok);
`endif

  assign accept   = req_valid & req_ready;
  assign rd_issue = accept & ~req_we;
  assign wr_issue = accept & req_we;

  assign mem_rdaddress = req_addr;
  assign mem_wraddress = req_addr;
  assign mem_data      = req_wdata;
  assign mem_rden      = rd_issue;
  assign mem_wren      = wr_issue;

`ifdef DMEM_WRITE_ACK_EN
  logic inflight_wr;
  logic fifo_wr [RSP_DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight    <= 1'b0;
      inflight_wr <= 1'b0;
    end else begin
      inflight    <= accept;
      inflight_wr <= wr_issue;
    end
  end

  assign push_data = inflight_wr ? '0 : mem_q;

  always_ff @(posedge clock) begin
    if (push) fifo_wr[wr_ptr] <= inflight_wr;
  end

  assign rsp_is_write = rsp_valid & fifo_wr[rd_ptr];
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) inflight <= 1'b0;
    else          inflight <= rd_issue;
  end

  assign push_data = mem_q;
`endif

  // mem_q is only valid the cycle after issue, so the in-flight flag is the push strobe.
  assign push = inflight;
  assign pop  = rsp_valid & rsp_ready;

  always_ff @(posedge clock) begin
    if (push) fifo_data[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rsp_valid = (count != '0);
  assign rsp_rdata = fifo_data[rd_ptr];
  assign busy      = inflight | (count != '0);

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    push |-> ({1'b0, count} != DEPTH_C));

endmodule
